// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the four-requester round-robin mux arbiter.
package mux4_arb_pkg;

    // Arbiter sequencing states.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int N_REQ = 4;   // number of requesters sharing the channel
    localparam int SEL_W = 2;   // width of the mux select / requester index

endpackage : mux4_arb_pkg

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Round-robin winner selection: the first set request bit found when
// searching ptr+1, ptr+2, ... (mod 4), so the requester at ptr has the
// lowest priority.
module rr_pick
    import mux4_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    // Scan the four positions after ptr and keep the first requester found.
    always_comb begin
        logic found;
        int   idx;
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment; a path that leaves one unassigned
        // infers a latch.
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && req[idx]) begin
                winner = SEL_W'(idx);
                found  = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule : rr_pick

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and sequencer sharing one W-bit 4:1 data channel
// between four requesters. One requester is granted at a time and keeps the
// channel for a multi-beat transfer, ended by its last beat, by the
// MAX_BEATS limit (with a preempt pulse) or by dropping its request.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int W         = 4,
    parameter int MAX_BEATS = 8    // legal range 1..255
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          in_valid,
    input  logic [N_REQ-1:0]          in_last,
    input  logic [N_REQ-1:0][W-1:0]   in_data,
    output logic [N_REQ-1:0]          in_ready,
    output logic                      out_valid,
    output logic                      out_last,
    output logic [W-1:0]              out_data,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          s,
    output logic [N_REQ-1:0]          gnt,
    output logic                      busy,
    output logic                      preempt
);

    localparam logic [7:0] LAST_CNT = 8'(MAX_BEATS - 1);

    arb_state_t         state_q,    state_d;
    logic [SEL_W-1:0]   ptr_q,      ptr_d;
    logic [SEL_W-1:0]   s_q,        s_d;
    logic [N_REQ-1:0]   gnt_q,      gnt_d;
    logic [7:0]         beat_cnt_q, beat_cnt_d;
    logic               preempt_q,  preempt_d;

    logic [SEL_W-1:0]   winner;
    logic               any_req;
    logic               accept;

    rr_pick u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any_req)
    );

    // Route the granted requester's handshake and data to the consumer;
    // everything is quiet while idle.
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        in_ready  = '0;
        out_data  = in_data[s_q];
        if (state_q == GRANT) begin
            out_valid      = in_valid[s_q];
            out_last       = in_last[s_q];
            in_ready[s_q]  = out_ready;
        end
    end

    assign accept = out_valid & out_ready;

    // Next-state logic: arbitrate in IDLE, count beats and decide release
    // in GRANT (last beat, beat limit, abandoned request, in that order).
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        s_d        = s_q;
        gnt_d      = gnt_q;
        beat_cnt_d = beat_cnt_q;
        preempt_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d    = GRANT;
                    s_d        = winner;
                    gnt_d      = N_REQ'(1) << winner;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if ((accept && out_last) ||
                    (accept && beat_cnt_q == LAST_CNT) ||
                    (!req[s_q] && !accept)) begin
                    state_d    = IDLE;
                    ptr_d      = s_q;
                    gnt_d      = '0;
                    beat_cnt_d = '0;
                    preempt_d  = accept && !out_last && (beat_cnt_q == LAST_CNT);
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with asynchronous reset; ptr starts at 3 so requester 0
    // has top priority after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= SEL_W'(N_REQ - 1);
            s_q        <= '0;
            gnt_q      <= '0;
            beat_cnt_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            s_q        <= s_d;
            gnt_q      <= gnt_d;
            beat_cnt_q <= beat_cnt_d;
            preempt_q  <= preempt_d;
        end
    end

    assign s       = s_q;
    assign gnt     = gnt_q;
    assign busy    = (state_q == GRANT);
    assign preempt = preempt_q;

endmodule : mux4_rr_arbiter
